kvs_vs_regex_result_joiner: RTL and testbench

Downstream stage of the regex engine top: consumes the in-order per-value match decisions (found_loc/found_valid/found_ready) and re-joins each one with the metadata word for the same value (key/address/ID), captured when the value was dispatched into the regex engines. Emits joined records to the response path, optionally dropping non-matching entries, and keeps match statistics. Single clock domain (slow clk), same as the regex top's outward interface.

---
 rtl/kvs_vs_regex_result_joiner_pkg.sv | 19 +
 rtl/kvs_vs_meta_fifo.sv | 59 +++++
 rtl/kvs_vs_regex_result_joiner.sv | 88 ++++++++
 tb/tb_kvs_vs_regex_result_joiner.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kvs_vs_regex_result_joiner_pkg.sv
// Shared types and helpers for the regex result joiner: default widths, output record, saturation step.
package kvs_vs_regex_result_joiner_pkg;

  localparam int META_WIDTH_DEF     = 64;
  localparam int FIFO_ADDR_BITS_DEF = 5;
  localparam int STAT_WIDTH_DEF     = 32;

  // Joined record at the default metadata width; the top re-declares it at its parameterised width.
  typedef struct packed {
    logic [META_WIDTH_DEF-1:0] meta;
    logic                      match;
  } join_rec_t;

  // Increment amount for a saturating counter: nothing once the counter is all-ones.
  function automatic logic sat_step(input logic inc, input logic at_max);
    return inc && !at_max;
  endfunction

endpackage

// File: rtl/kvs_vs_meta_fifo.sv
// Synchronous metadata FIFO: head word feeds the joiner's output register, count-derived full/empty.
// A push into a full FIFO is refused even when a pop happens in the same cycle.
module kvs_vs_meta_fifo #(
  parameter int WIDTH     = 64,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic [WIDTH-1:0]     i_push_dat,
  output logic                 o_push_rdy,
  input  logic                 i_pop,
  output logic [WIDTH-1:0]     o_head_dat,
  output logic [ADDR_BITS:0]   o_count
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [ADDR_BITS:0]   r_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign w_full     = (r_count == (ADDR_BITS+1)'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_do_push  = i_push && !w_full;
  assign w_do_pop   = i_pop && !w_empty;
  assign o_push_rdy = !w_full;
  assign o_count    = r_count;
  // Head is read from the array; a word written this cycle only becomes visible once count says so.
  assign o_head_dat = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/kvs_vs_regex_result_joiner.sv
// Re-joins in-order regex match decisions with the metadata captured at dispatch, one join per cycle.
// Output register is held while stalled; non-matching records may be dropped; saturating statistics.
module kvs_vs_regex_result_joiner
  import kvs_vs_regex_result_joiner_pkg::*;
#(
  parameter int META_WIDTH     = META_WIDTH_DEF,
  parameter int FIFO_ADDR_BITS = FIFO_ADDR_BITS_DEF,
  parameter int STAT_WIDTH     = STAT_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [META_WIDTH-1:0]   meta_data,
  input  logic                    meta_valid,
  output logic                    meta_ready,
  input  logic                    dec_match,
  input  logic                    dec_valid,
  output logic                    dec_ready,
  input  logic                    cfg_drop_nonmatch,
  output logic [META_WIDTH-1:0]   out_data,
  output logic                    out_match,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [STAT_WIDTH-1:0]   stat_total,
  output logic [STAT_WIDTH-1:0]   stat_matched,
  output logic [FIFO_ADDR_BITS:0] fifo_count
);

  typedef struct packed {
    logic [META_WIDTH-1:0] meta;
    logic                  match;
  } out_rec_t;

  out_rec_t              r_out;
  logic                  r_out_vld;
  logic [STAT_WIDTH-1:0] r_total;
  logic [STAT_WIDTH-1:0] r_matched;

  logic [META_WIDTH-1:0] w_head;
  logic                  w_free;
  logic                  w_join;
  logic                  w_keep;

  kvs_vs_meta_fifo #(
    .WIDTH     (META_WIDTH),
    .ADDR_BITS (FIFO_ADDR_BITS)
  ) u_meta_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (meta_valid),
    .i_push_dat (meta_data),
    .o_push_rdy (meta_ready),
    .i_pop      (w_join),
    .o_head_dat (w_head),
    .o_count    (fifo_count)
  );

  assign w_free    = !r_out_vld || out_ready;
  assign dec_ready = (fifo_count != '0) && w_free;
  assign w_join    = dec_valid && dec_ready;
  assign w_keep    = dec_match || !cfg_drop_nonmatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out     <= '0;
      r_out_vld <= 1'b0;
      r_total   <= '0;
      r_matched <= '0;
    end else begin
      if (w_join && w_keep) begin
        r_out     <= '{meta: w_head, match: dec_match};
        r_out_vld <= 1'b1;
      end else if (w_free) begin
        // Either the held record was taken or a dropped join left the slot empty.
        r_out_vld <= 1'b0;
      end
      // Dropped records still count; both counters stick at all-ones.
      r_total   <= r_total + STAT_WIDTH'(sat_step(w_join, &r_total));
      r_matched <= r_matched + STAT_WIDTH'(sat_step(w_join && dec_match, &r_matched));
    end
  end

  assign out_data     = r_out.meta;
  assign out_match    = r_out.match;
  assign out_valid    = r_out_vld;
  assign stat_total   = r_total;
  assign stat_matched = r_matched;

endmodule

// File: tb/tb_kvs_vs_regex_result_joiner.sv
// Scoreboard bench for the regex result joiner: directed vectors, expected records queued at join time.
module tb_kvs_vs_regex_result_joiner;

  localparam int MW = 64;
  localparam int AB = 5;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [MW-1:0] meta_data;
  logic          meta_valid;
  logic          meta_ready;
  logic          dec_match;
  logic          dec_valid;
  logic          dec_ready;
  logic          cfg_drop_nonmatch;
  logic [MW-1:0] out_data;
  logic          out_match;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] stat_total;
  logic [SW-1:0] stat_matched;
  logic [AB:0]   fifo_count;

  int n_vec  = 0;
  int n_miss = 0;
  int n_out  = 0;

  logic [MW:0]   exp_q[$];
  logic [MW-1:0] meta_q[$];

  kvs_vs_regex_result_joiner #(
    .META_WIDTH     (MW),
    .FIFO_ADDR_BITS (AB),
    .STAT_WIDTH     (SW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .meta_data         (meta_data),
    .meta_valid        (meta_valid),
    .meta_ready        (meta_ready),
    .dec_match         (dec_match),
    .dec_valid         (dec_valid),
    .dec_ready         (dec_ready),
    .cfg_drop_nonmatch (cfg_drop_nonmatch),
    .out_data          (out_data),
    .out_match         (out_match),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .stat_total        (stat_total),
    .stat_matched      (stat_matched),
    .fifo_count        (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s", name);
  endtask

  // Monitor: every accepted output record is compared with the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) fail_now("unexpected_out_record");
      else check("out_record", {7'd0, out_data, out_match}, {7'd0, exp_q.pop_front()});
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    meta_valid = 1'b0;
    dec_valid  = 1'b0;
    dec_match  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    meta_q.delete();
    n_out = 0;
    @(negedge clk);
    check("rst_out_valid", 72'(out_valid), 72'd0);
    check("rst_out_rec", {7'd0, out_data, out_match}, 72'd0);
    check("rst_stat_total", 72'(stat_total), 72'd0);
    check("rst_stat_matched", 72'(stat_matched), 72'd0);
    check("rst_fifo_count", 72'(fifo_count), 72'd0);
    check("rst_meta_ready", 72'(meta_ready), 72'd1);
    check("rst_dec_ready", 72'(dec_ready), 72'd0);
  endtask

  task automatic push_metas(input logic [MW-1:0] base, input int n);
    int idx   = 0;
    int guard = 0;
    bit rdy;
    @(posedge clk);
    #1;
    while (idx < n && guard < 200) begin
      meta_valid = 1'b1;
      meta_data  = base + MW'(idx);
      @(negedge clk);
      rdy = meta_ready;
      @(posedge clk);
      guard++;
      if (rdy) begin
        meta_q.push_back(meta_data);
        idx++;
      end
      #1;
    end
    meta_valid = 1'b0;
    if (idx < n) fail_now("meta_push_timeout");
  endtask

  // Hold dec_valid, advancing through bits[] on each accepted cycle; optional 1-cycle latency check.
  task automatic run_decs(input logic [31:0] bits, input int n, input bit lat_chk, output int cycles);
    int          idx  = 0;
    bit          rdy;
    bit          keep;
    bit          pend = 1'b0;
    bit          pend_keep = 1'b0;
    logic [MW:0] pend_rec = '0;
    logic [MW-1:0] m;
    cycles = 0;
    @(posedge clk);
    #1;
    while (idx < n && cycles < 200) begin
      dec_valid = 1'b1;
      dec_match = bits[idx];
      @(negedge clk);
      if (pend) begin
        check("lat_out_valid", 72'(out_valid), 72'(pend_keep));
        if (pend_keep) check("lat_out_rec", {7'd0, out_data, out_match}, {7'd0, pend_rec});
        pend = 1'b0;
      end
      rdy = dec_ready;
      @(posedge clk);
      cycles++;
      if (rdy) begin
        if (meta_q.size() == 0) begin
          fail_now("dec_ready_without_meta");
          m = '0;
        end else begin
          m = meta_q.pop_front();
        end
        keep = bits[idx] || !cfg_drop_nonmatch;
        if (keep) exp_q.push_back({m, bits[idx]});
        if (lat_chk) begin
          pend      = 1'b1;
          pend_keep = keep;
          pend_rec  = {m, bits[idx]};
        end
        idx++;
      end
      #1;
    end
    dec_valid = 1'b0;
    dec_match = 1'b0;
    if (pend) begin
      @(negedge clk);
      check("lat_out_valid", 72'(out_valid), 72'(pend_keep));
      if (pend_keep) check("lat_out_rec", {7'd0, out_data, out_match}, {7'd0, pend_rec});
    end
    if (idx < n) fail_now("dec_join_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int cyc;
    rst = 1'b1;
    meta_data = '0;
    meta_valid = 1'b0;
    dec_match = 1'b0;
    dec_valid = 1'b0;
    cfg_drop_nonmatch = 1'b0;
    out_ready = 1'b1;

    // In-order join, nothing dropped: (A0,1),(A1,0),(A2,1),(A3,1).
    do_reset();
    push_metas(64'hA0, 4);
    run_decs(32'b1101, 4, 1'b1, cyc);
    repeat (2) @(negedge clk);
    check("t1_outputs", 72'(n_out), 72'd4);
    check("t1_pending", 72'(exp_q.size()), 72'd0);
    check("t1_stat_total", 72'(stat_total), 72'd4);
    check("t1_stat_matched", 72'(stat_matched), 72'd3);

    // Drop non-matching: only A0, A2, A3 leave.
    do_reset();
    cfg_drop_nonmatch = 1'b1;
    push_metas(64'hA0, 4);
    run_decs(32'b1101, 4, 1'b1, cyc);
    repeat (2) @(negedge clk);
    check("t2_outputs", 72'(n_out), 72'd3);
    check("t2_pending", 72'(exp_q.size()), 72'd0);
    check("t2_stat_total", 72'(stat_total), 72'd4);
    check("t2_stat_matched", 72'(stat_matched), 72'd3);
    check("t2_fifo_count", 72'(fifo_count), 72'd0);
    cfg_drop_nonmatch = 1'b0;

    // Decision arrives before its metadata: waits, no write-through on the push cycle.
    do_reset();
    @(posedge clk);
    #1;
    dec_valid = 1'b1;
    dec_match = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_early_dec_ready", 72'(dec_ready), 72'd0);
      @(posedge clk);
      #1;
    end
    meta_valid = 1'b1;
    meta_data  = 64'hB5;
    @(negedge clk);
    check("t3_push_cycle_dec_ready", 72'(dec_ready), 72'd0);
    @(posedge clk);
    #1;
    meta_valid = 1'b0;
    meta_q.push_back(64'hB5);
    @(negedge clk);
    check("t3_after_push_dec_ready", 72'(dec_ready), 72'd1);
    @(posedge clk);
    void'(meta_q.pop_front());
    exp_q.push_back({64'hB5, 1'b1});
    #1;
    dec_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("t3_outputs", 72'(n_out), 72'd1);
    check("t3_pending", 72'(exp_q.size()), 72'd0);

    // Fill to 32, 33rd push refused, one join reopens the FIFO.
    do_reset();
    push_metas(64'h100, 32);
    @(negedge clk);
    check("t4_full_meta_ready", 72'(meta_ready), 72'd0);
    check("t4_full_count", 72'(fifo_count), 72'd32);
    @(posedge clk);
    #1;
    meta_valid = 1'b1;
    meta_data  = 64'h1FF;
    @(negedge clk);
    check("t4_push33_meta_ready", 72'(meta_ready), 72'd0);
    @(posedge clk);
    #1;
    meta_valid = 1'b0;
    @(negedge clk);
    check("t4_push33_count", 72'(fifo_count), 72'd32);
    run_decs(32'h1, 1, 1'b0, cyc);
    @(negedge clk);
    check("t4_after_pop_meta_ready", 72'(meta_ready), 72'd1);
    check("t4_after_pop_count", 72'(fifo_count), 72'd31);
    run_decs(32'h7FFF_FFFF, 31, 1'b0, cyc);
    repeat (2) @(negedge clk);
    check("t4_pending", 72'(exp_q.size()), 72'd0);
    check("t4_outputs", 72'(n_out), 72'd32);

    // Stall with a held record for 5 cycles, then one join per cycle.
    do_reset();
    out_ready = 1'b0;
    push_metas(64'hC0, 3);
    run_decs(32'h1, 1, 1'b0, cyc);
    @(posedge clk);
    #1;
    dec_valid = 1'b1;
    dec_match = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_hold_valid", 72'(out_valid), 72'd1);
      check("t5_hold_rec", {7'd0, out_data, out_match}, {7'd0, 64'hC0, 1'b1});
      check("t5_hold_dec_ready", 72'(dec_ready), 72'd0);
      check("t5_hold_count", 72'(fifo_count), 72'd2);
      @(posedge clk);
      #1;
    end
    dec_valid = 1'b0;
    out_ready = 1'b1;
    run_decs(32'b10, 2, 1'b1, cyc);
    check("t5_burst_cycles", 72'(cyc), 72'd2);
    repeat (2) @(negedge clk);
    check("t5_outputs", 72'(n_out), 72'd3);
    check("t5_pending", 72'(exp_q.size()), 72'd0);

    // 20 matches on a 4-bit counter: both statistics stick at 15.
    do_reset();
    push_metas(64'hD0, 20);
    run_decs(32'hF_FFFF, 20, 1'b0, cyc);
    repeat (2) @(negedge clk);
    check("t6_sat_total", 72'(stat_total), 72'd15);
    check("t6_sat_matched", 72'(stat_matched), 72'd15);
    check("t6_pending", 72'(exp_q.size()), 72'd0);

    // Reset with metadata pending and a record held.
    push_metas(64'hE0, 3);
    out_ready = 1'b0;
    run_decs(32'h1, 1, 1'b0, cyc);
    @(negedge clk);
    check("t6_prereset_valid", 72'(out_valid), 72'd1);
    check("t6_prereset_count", 72'(fifo_count), 72'd2);
    do_reset();
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_postreset_outputs", 72'(n_out), 72'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
